muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the execute stage. It accepts one M-type operation from execute, runs it over a fixed number of cycles on a shift/add datapath, and holds the pipeline with `stall` until the result is ready. The result is handed back to execute for the normal `alu_result` path into the EX/MEM register.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width.
- Iteration count is `XLEN`; the counter width is `$clog2(XLEN)`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  launch request. Execute drives it as `v_de && is_muldiv && !flush`.
- `funct3`  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value, after bypass.
- `op_b`  in  XLEN  rs2 value, after bypass.
- `flush`  in  1  abort the in-flight op.
- `stall`  out  1  freezes fetch/decode/execute (combinational).
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  op result; held until the next accepted start.

## Operation
States: IDLE, PREP, RUN, FIX, DONE.
- **IDLE:** `start` is accepted → PREP. Latch `funct3`, `op_a` and `op_b`.
- **PREP:** take magnitudes of signed operands:
  - MULH: both operands signed.
  - MULHSU: `op_a` signed only.
  - DIV/REM: both operands signed.
  - Record the result sign. Clear the accumulator. Counter ← 0.
  - Special divide cases resolve here and go straight to DONE:
    - `op_b == 0`: quotient = all ones; remainder = `op_a`.
    - Signed DIV/REM with `op_a == 0x80000000` and `op_b == 0xFFFFFFFF`: quotient = 0x80000000; remainder = 0.
  - Otherwise → RUN.
- **RUN:** one iteration per cycle; counter increments. Leaves to FIX when counter == XLEN-1.
  - Multiply: shift-add over a 2·XLEN product.
  - Divide: restoring, one quotient bit per cycle; 2·XLEN remainder:quotient register.
- **FIX:** negate the magnitude if the recorded sign is negative. Select the low half (MUL), the high half (MULH*), the quotient or the remainder. The remainder takes the dividend's sign. → DONE.
- **DONE:** `done` = 1, `result` is driven. → IDLE unconditionally.

Rules:
- `stall` = (IDLE && `start`) || state ∈ {PREP, RUN, FIX}. It is low in DONE, so the pipeline advances in the same cycle `done` is high.
- `start` is ignored in every state except IDLE.
- `flush` in any state other than IDLE → IDLE at the next edge. No `done`; `result` is unchanged. `flush` takes priority over the state's normal transition.
- `flush` and `start` both high in IDLE: the start is not accepted.
- All arithmetic is XLEN/2·XLEN unsigned internally. Negation is two's complement with wrap.

## Timing
- Reset: state IDLE; `stall` = 0 unless `start` is high; `done` = 0; `result` = 0; counter = 0.
- `rst` mid-operation behaves like reset: IDLE at the next edge, no `done`.
- Normal op, with `start` sampled at edge E0:
  - PREP in cycle 1.
  - RUN in cycles 2..XLEN+1.
  - FIX in cycle XLEN+2.
  - DONE in cycle XLEN+3 (cycle 35 for XLEN = 32).
- Special divide case: PREP in cycle 1, DONE in cycle 2.
- Back-to-back ops: the earliest next start is the cycle after DONE, with `stall` asserted again combinationally.
- `result` and `done` are registered; there is no combinational path from inputs to them.

## Structure
- Add to the shared `riscv_structures.sv` package:
  - `md_state_e` (the five states above).
  - `md_op_e` (the eight funct3 encodings).
  - A helper `is_signed_a` / `is_signed_b` truth mapping.
- Sub-module `muldiv_core` holds the datapath: operand/accumulator registers, shared XLEN+1 adder/subtractor, shift control inputs.
- `muldiv_ctrl` holds the FSM, counter, special-case detection and the stall/done logic.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) → `result` 0xFFFFFFEB. `done` exactly at cycle 35. `stall` high in cycles 0–34, low in cycle 35.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and the matching REM → 0. Each of these gives `done` at cycle 2.
- `flush` in RUN cycle 10 → IDLE next cycle, no `done`, `result` keeps its old value. A new `start` two cycles later completes normally.
- `rst` in RUN → all outputs 0 next cycle. A `start` during DONE is ignored; `start` and `flush` together in IDLE → no launch.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit: FSM states,
// funct3 op encodings and operand-signedness helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(input md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Shift/add multiply and restoring divide datapath: one bit per i_step, sign
// fix-up on i_fix, special divide results on i_special; result is registered.
module muldiv_core
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  md_op_e          i_op,
    input  logic            i_prep,
    input  logic            i_step,
    input  logic            i_special,
    input  logic            i_fix,
    output logic [XLEN-1:0] o_a_raw,
    output logic [XLEN-1:0] o_b_raw,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_result;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_is_div;
    logic [XLEN:0]     w_add_x;
    logic [XLEN:0]     w_add_y;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [2*XLEN-1:0] w_div_nxt;
    logic              w_neg_res;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;
    logic [XLEN-1:0]   w_spec_res;

    assign w_a_neg  = is_signed_a(i_op) & r_a[XLEN-1];
    assign w_b_neg  = is_signed_b(i_op) & r_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;
    assign w_is_div = is_div_op(i_op);

    // One XLEN+1 adder: hi + mcand for multiply, (rem<<1 | next bit) - divisor for divide.
    assign w_add_x = w_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
    assign w_add_y = {1'b0, r_b} ^ {(XLEN+1){w_is_div}};
    assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(XLEN+1){1'b0}}, w_is_div};

    assign w_mul_nxt = r_acc[0] ? {w_sum[XLEN:0], r_acc[XLEN-1:1]}
                                : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};
    assign w_div_nxt = w_sum[XLEN+1] ? {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                                     : {r_acc[2*XLEN-2:0], 1'b0};

    assign w_neg_res = r_neg_a ^ r_neg_b;
    assign w_prod    = w_neg_res ? -r_acc : r_acc;
    assign w_quo     = w_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem     = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = w_rem;
        case (i_op)
            OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo;
            default:                       w_fix_res = w_rem;
        endcase
    end

    // Divide-by-zero gives all-ones / dividend; signed overflow gives dividend / zero.
    always_comb begin
        if (r_b == '0) w_spec_res = is_rem_op(i_op) ? r_a : '1;
        else           w_spec_res = is_rem_op(i_op) ? '0 : r_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_a <= i_op_a;
                r_b <= i_op_b;
            end
            if (i_prep) begin
                r_b     <= w_b_mag;
                r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                r_neg_a <= w_a_neg;
                r_neg_b <= w_b_neg;
            end
            if (i_step)    r_acc    <= w_is_div ? w_div_nxt : w_mul_nxt;
            if (i_special) r_result <= w_spec_res;
            if (i_fix)     r_result <= w_fix_res;
        end
    end

    assign o_a_raw  = r_a;
    assign o_b_raw  = r_b;
    assign o_result = r_result;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: IDLE/PREP/RUN/FIX/DONE, done XLEN+3 cycles after start (2 for special divides).
// stall holds execute until the DONE cycle; flush or rst abandons the op with no done.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       r_state;
    md_state_e       w_next;
    md_op_e          r_op;
    logic [CW-1:0]   r_cnt;

    logic            w_load;
    logic            w_prep;
    logic            w_step;
    logic            w_fix;
    logic            w_special;
    logic            w_is_special;
    logic [XLEN-1:0] w_a_raw;
    logic [XLEN-1:0] w_b_raw;

    assign w_is_special = is_div_op(r_op) &
                          ((w_b_raw == '0) |
                           (is_signed_a(r_op) & (w_a_raw == MINV) & (w_b_raw == '1)));

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        w_load    = 1'b0;
        w_prep    = 1'b0;
        w_step    = 1'b0;
        w_fix     = 1'b0;
        w_special = 1'b0;
        case (r_state)
            MD_IDLE: begin
                stall = start;
                if (start && !flush) begin
                    w_load = 1'b1;
                    w_next = MD_PREP;
                end
            end
            MD_PREP: begin
                stall = 1'b1;
                if (flush) begin
                    w_next = MD_IDLE;
                end else if (w_is_special) begin
                    w_special = 1'b1;
                    w_next    = MD_DONE;
                end else begin
                    w_prep = 1'b1;
                    w_next = MD_RUN;
                end
            end
            MD_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    w_next = MD_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == LAST) w_next = MD_FIX;
                end
            end
            MD_FIX: begin
                stall = 1'b1;
                if (flush) begin
                    w_next = MD_IDLE;
                end else begin
                    w_fix  = 1'b1;
                    w_next = MD_DONE;
                end
            end
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_op    <= OP_MUL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) r_op <= md_op_e'(funct3);
            if (r_state == MD_PREP) r_cnt <= '0;
            else if (w_step)        r_cnt <= r_cnt + 1'b1;
        end
    end

    assign done = (r_state == MD_DONE);

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_op_a    (op_a),
        .i_op_b    (op_b),
        .i_op      (r_op),
        .i_prep    (w_prep),
        .i_step    (w_step),
        .i_special (w_special),
        .i_fix     (w_fix),
        .o_a_raw   (w_a_raw),
        .o_b_raw   (w_b_raw),
        .o_result  (result)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, random ops against an arithmetic
// reference model, and hand sequences for flush, reset and ignored starts.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op (start held for cycle 0 only), return result and the cycle done was seen.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cyc, output int stall_bad);
        res       = '0;
        cyc       = -1;
        stall_bad = 0;
        tick();
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                res = result;
                if (stall !== 1'b0) stall_bad++;
                break;
            end
            if (stall !== 1'b1) stall_bad++;
            tick();
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pv;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: begin p = ua * ub; pv = p; return pv[31:0];  end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin p = ua * ub; pv = p; return pv[63:32]; end
            default: ;
        endcase
        if (b == 32'd0) return (f3 == 3'd6 || f3 == 3'd7) ? a : 32'hFFFFFFFF;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return (f3 == 3'd4) ? 32'h80000000 : 32'h0;
        case (f3)
            3'd4:    return 32'(ia / ib);
            3'd5:    return a / b;
            3'd6:    return 32'(ia % ib);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_cyc(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (f3[2] && (b == 32'd0 ||
            ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 2;
        return 35;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        int          cyc, sbad, ndone, sel;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 35};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 35};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 35};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 35};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 35};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 35};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       35};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        35};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 2};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,        32'd5,        2};
        vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2};
        vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 2};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall",  32'(stall),  32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, cyc, sbad);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_stall", i), 32'(sbad), 32'd0);
        end

        // Flush during RUN cycle 10: no done, result keeps 14 from the DIVU.
        do_op(3'd5, 32'd100, 32'd7, res, cyc, sbad);
        check("pre_flush_result", res, 32'd14);
        tick();
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall", 32'(stall), 32'd0);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(ndone), 32'd0);
        check("flush_result_held", result, 32'd14);
        do_op(3'd0, 32'd3, 32'd5, res, cyc, sbad);
        check("after_flush_result", res, 32'd15);
        check("after_flush_cycle", 32'(cyc), 32'd35);

        // Reset mid-RUN clears every output on the next cycle.
        tick();
        funct3 = 3'd3; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_stall",  32'(stall), 32'd0);
        check("rst_run_done",   32'(done),  32'd0);
        check("rst_run_result", result,     32'd0);

        // Start raised in DONE is ignored.
        tick();
        funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (34) tick();
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        check("done_cycle_done",   32'(done),  32'd1);
        check("done_cycle_stall",  32'(stall), 32'd0);
        check("done_cycle_result", result,     32'd4);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(stall), 32'd0);

        // Start together with flush in IDLE does not launch.
        tick();
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("idle_start_flush_stall", 32'(stall), 32'd1);
        tick();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_start_flush_no_launch", 32'(stall), 32'd0);

        // Random back-to-back ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            rf  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            do_op(rf, ra, rb, res, cyc, sbad);
            check($sformatf("rand%0d_f%0d_result", n, rf), res, model(rf, ra, rb));
            check($sformatf("rand%0d_cycle", n), 32'(cyc), 32'(model_cyc(rf, ra, rb)));
            check($sformatf("rand%0d_stall", n), 32'(sbad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
